plab4_net_tdm_term_ifc: RTL and testbench

Terminal-side network interface for the two-domain, time-multiplexed ring router. It is the transmit/receive end of the router terminal port. It buffers per-domain injection traffic and drives the router terminal input (`val`/`rdy`/`msg`/`sd`) only during the owning domain's epoch. It also demultiplexes the router terminal output by its `sd` tag into per-domain ejection queues. One instance sits between each router and its two domain clients.

---
 rtl/plab4_net_tdm_term_ifc_pkg.sv | 27 ++
 rtl/plab4_net_tdm_term_ifc_queue.sv | 71 +++++++
 rtl/plab4_net_tdm_term_ifc.sv | 160 ++++++++++++++++
 tb/tb_plab4_net_tdm_term_ifc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plab4_net_tdm_term_ifc_pkg.sv
// Shared definitions for the two-domain TDM network: domain encodings, network
// message layout helpers and the epoch-counter width.
package plab4_net_tdm_term_ifc_pkg;

  // Domain tag carried on the sd wires and held in the epoch register.
  typedef enum logic {
    D0 = 1'b0,
    D1 = 1'b1
  } domain_e;

  // Network message layout, MSB first: {dest, src, opaque, payload}.
  function automatic int unsigned net_msg_nbits(input int unsigned p, input int unsigned o,
                                                input int unsigned s);
    return p + o + 2 * s;
  endfunction

  // Bit offset of the lowest src bit.
  function automatic int unsigned net_msg_src_lsb(input int unsigned p, input int unsigned o);
    return p + o;
  endfunction

  // Width of the slot counter inside one epoch; at least one bit.
  function automatic int unsigned epoch_cnt_nbits(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/plab4_net_tdm_term_ifc_queue.sv
// Normal (non-bypass, non-pipe) FIFO used for all four terminal queues.
// Depth must be a power of two so the pointers wrap naturally.
module plab4_net_tdm_term_ifc_queue #(
  parameter int unsigned Width = 41,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val_i,
  output logic             enq_rdy_o,
  input  logic [Width-1:0] enq_msg_i,
  output logic             deq_val_o,
  input  logic             deq_rdy_i,
  output logic [Width-1:0] deq_msg_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrW:0] CntFull = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             do_enq, do_deq;

  // Handshake status straight from the occupancy count.
  always_comb begin
    enq_rdy_o = (cnt_q != CntFull);
    deq_val_o = (cnt_q != '0);
    deq_msg_o = mem_q[rd_ptr_q];
    do_enq    = enq_val_i && enq_rdy_o;
    do_deq    = deq_val_o && deq_rdy_i;
  end

  // Next-state: write at tail, advance head, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_enq) begin
      mem_d[wr_ptr_q] = enq_msg_i;
      wr_ptr_d        = wr_ptr_q + AddrW'(1);
    end
    if (do_deq) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    unique case ({do_enq, do_deq})
      2'b10:   cnt_d = cnt_q + (AddrW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AddrW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/plab4_net_tdm_term_ifc.sv
// Terminal-side interface of the two-domain TDM ring router. Buffers per-domain
// injection traffic, offers it to the router only during the owning domain's
// epoch, and demultiplexes router output into per-domain ejection queues.
// Optional feature: PLAB4_NET_TDM_IFC_STAMP_SRC_EN overwrites the src field of
// injected messages with p_router_id.
module plab4_net_tdm_term_ifc
  import plab4_net_tdm_term_ifc_pkg::*;
#(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_opaque_nbits  = 3,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_router_id     = 0,
  parameter int unsigned p_num_msgs      = 2,
  parameter int unsigned p_epoch_cycles  = 1,
  localparam int unsigned c_net_msg_nbits =
    net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       d0_req_val,
  output logic                       d0_req_rdy,
  input  logic [c_net_msg_nbits-1:0] d0_req_msg,
  input  logic                       d1_req_val,
  output logic                       d1_req_rdy,
  input  logic [c_net_msg_nbits-1:0] d1_req_msg,
  output logic                       d0_resp_val,
  input  logic                       d0_resp_rdy,
  output logic [c_net_msg_nbits-1:0] d0_resp_msg,
  output logic                       d1_resp_val,
  input  logic                       d1_resp_rdy,
  output logic [c_net_msg_nbits-1:0] d1_resp_msg,
  output logic                       net_out_val,
  input  logic                       net_out_rdy,
  output logic [c_net_msg_nbits-1:0] net_out_msg,
  output logic                       net_out_sd,
  input  logic                       net_in_val,
  output logic                       net_in_rdy,
  input  logic [c_net_msg_nbits-1:0] net_in_msg,
  input  logic                       net_in_sd
);

  localparam int unsigned SlotW    = epoch_cnt_nbits(p_epoch_cycles);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(p_epoch_cycles - 1);
  localparam int unsigned SrcLsb   = net_msg_src_lsb(p_payload_nbits, p_opaque_nbits);

`ifdef PLAB4_NET_TDM_IFC_STAMP_SRC_EN
  localparam bit StampSrc = 1'b1;
`else
  localparam bit StampSrc = 1'b0;
`endif

  domain_e          epoch_q, epoch_d;
  logic [SlotW-1:0] slot_cnt_q, slot_cnt_d;

  logic [c_net_msg_nbits-1:0] iq0_enq_msg, iq1_enq_msg;
  logic [c_net_msg_nbits-1:0] iq0_deq_msg, iq1_deq_msg;
  logic iq0_deq_val, iq1_deq_val, iq0_deq_rdy, iq1_deq_rdy;
  logic eq0_enq_val, eq1_enq_val, eq0_enq_rdy, eq1_enq_rdy;

  // Epoch counter: p_epoch_cycles slots per epoch, then hand over to the other domain.
  always_comb begin
    slot_cnt_d = slot_cnt_q + SlotW'(1);
    epoch_d    = epoch_q;
    if (slot_cnt_q == SlotLast) begin
      slot_cnt_d = '0;
      epoch_d    = (epoch_q == D0) ? D1 : D0;
    end
  end

  // Epoch state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      epoch_q    <= D0;
      slot_cnt_q <= '0;
    end else begin
      epoch_q    <= epoch_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  // Injected message formatting: optionally stamp our router id into src.
  always_comb begin
    iq0_enq_msg = d0_req_msg;
    iq1_enq_msg = d1_req_msg;
    if (StampSrc) begin
      iq0_enq_msg[SrcLsb +: p_srcdest_nbits] = p_srcdest_nbits'(p_router_id);
      iq1_enq_msg[SrcLsb +: p_srcdest_nbits] = p_srcdest_nbits'(p_router_id);
    end
  end

  // Epoch-indexed muxes: only the owning domain's queue sees the router, and
  // ejected traffic is steered purely by its sd tag.
  always_comb begin
    iq0_deq_rdy = (epoch_q == D0) && net_out_rdy;
    iq1_deq_rdy = (epoch_q == D1) && net_out_rdy;
    net_out_sd  = epoch_q;
    net_out_val = (epoch_q == D1) ? iq1_deq_val : iq0_deq_val;
    net_out_msg = (epoch_q == D1) ? iq1_deq_msg : iq0_deq_msg;
    eq0_enq_val = net_in_val && (net_in_sd == D0);
    eq1_enq_val = net_in_val && (net_in_sd == D1);
    net_in_rdy  = (net_in_sd == D1) ? eq1_enq_rdy : eq0_enq_rdy;
  end

  plab4_net_tdm_term_ifc_queue #(
    .Width (c_net_msg_nbits),
    .Depth (p_num_msgs)
  ) u_iq0 (
    .clk       (clk),
    .reset     (reset),
    .enq_val_i (d0_req_val),
    .enq_rdy_o (d0_req_rdy),
    .enq_msg_i (iq0_enq_msg),
    .deq_val_o (iq0_deq_val),
    .deq_rdy_i (iq0_deq_rdy),
    .deq_msg_o (iq0_deq_msg)
  );

  plab4_net_tdm_term_ifc_queue #(
    .Width (c_net_msg_nbits),
    .Depth (p_num_msgs)
  ) u_iq1 (
    .clk       (clk),
    .reset     (reset),
    .enq_val_i (d1_req_val),
    .enq_rdy_o (d1_req_rdy),
    .enq_msg_i (iq1_enq_msg),
    .deq_val_o (iq1_deq_val),
    .deq_rdy_i (iq1_deq_rdy),
    .deq_msg_o (iq1_deq_msg)
  );

  plab4_net_tdm_term_ifc_queue #(
    .Width (c_net_msg_nbits),
    .Depth (p_num_msgs)
  ) u_eq0 (
    .clk       (clk),
    .reset     (reset),
    .enq_val_i (eq0_enq_val),
    .enq_rdy_o (eq0_enq_rdy),
    .enq_msg_i (net_in_msg),
    .deq_val_o (d0_resp_val),
    .deq_rdy_i (d0_resp_rdy),
    .deq_msg_o (d0_resp_msg)
  );

  plab4_net_tdm_term_ifc_queue #(
    .Width (c_net_msg_nbits),
    .Depth (p_num_msgs)
  ) u_eq1 (
    .clk       (clk),
    .reset     (reset),
    .enq_val_i (eq1_enq_val),
    .enq_rdy_o (eq1_enq_rdy),
    .enq_msg_i (net_in_msg),
    .deq_val_o (d1_resp_val),
    .deq_rdy_i (d1_resp_rdy),
    .deq_msg_o (d1_resp_msg)
  );

endmodule

// File: tb/tb_plab4_net_tdm_term_ifc.sv
// Bench for plab4_net_tdm_term_ifc: directed stimulus, scoreboard queues per
// DUT queue, every output compared each cycle on the falling edge.
module tb_plab4_net_tdm_term_ifc;

  localparam int unsigned RouterId    = 5;
  localparam int unsigned NumMsgs     = 2;
  localparam int unsigned EpochCycles = 1;
  localparam int unsigned MsgW        = 41;

  typedef logic [MsgW-1:0] msg_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d0_req_val = 1'b0, d1_req_val = 1'b0;
  msg_t d0_req_msg = '0, d1_req_msg = '0;
  logic d0_req_rdy, d1_req_rdy;
  logic d0_resp_val, d1_resp_val;
  logic d0_resp_rdy = 1'b0, d1_resp_rdy = 1'b0;
  msg_t d0_resp_msg, d1_resp_msg;
  logic net_out_val, net_out_sd;
  logic net_out_rdy = 1'b0;
  msg_t net_out_msg;
  logic net_in_val = 1'b0, net_in_sd = 1'b0;
  logic net_in_rdy;
  msg_t net_in_msg = '0;

  int compared = 0;
  int mismatched = 0;

  // Scoreboard: expected contents of each DUT queue plus the epoch.
  msg_t m_iq0[$], m_iq1[$], m_eq0[$], m_eq1[$];
  bit   m_init = 1'b0;
  bit   m_epoch = 1'b0;
  int   m_slot = 0;
  bit   x_out_fire, x_in_fire, x_req0, x_req1, x_resp0, x_resp1;
  bit   acc0, acc1, acc_in;

  plab4_net_tdm_term_ifc #(
    .p_payload_nbits (32),
    .p_opaque_nbits  (3),
    .p_srcdest_nbits (3),
    .p_router_id     (RouterId),
    .p_num_msgs      (NumMsgs),
    .p_epoch_cycles  (EpochCycles)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d0_req_val  (d0_req_val),
    .d0_req_rdy  (d0_req_rdy),
    .d0_req_msg  (d0_req_msg),
    .d1_req_val  (d1_req_val),
    .d1_req_rdy  (d1_req_rdy),
    .d1_req_msg  (d1_req_msg),
    .d0_resp_val (d0_resp_val),
    .d0_resp_rdy (d0_resp_rdy),
    .d0_resp_msg (d0_resp_msg),
    .d1_resp_val (d1_resp_val),
    .d1_resp_rdy (d1_resp_rdy),
    .d1_resp_msg (d1_resp_msg),
    .net_out_val (net_out_val),
    .net_out_rdy (net_out_rdy),
    .net_out_msg (net_out_msg),
    .net_out_sd  (net_out_sd),
    .net_in_val  (net_in_val),
    .net_in_rdy  (net_in_rdy),
    .net_in_msg  (net_in_msg),
    .net_in_sd   (net_in_sd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic msg_t mk(input logic [2:0] dest, input logic [2:0] src,
                              input logic [2:0] op, input logic [31:0] pl);
    return {dest, src, op, pl};
  endfunction

  // What the DUT should hold after accepting an injected message.
  function automatic msg_t exp_inj(input msg_t m);
    msg_t r;
    r = m;
`ifdef PLAB4_NET_TDM_IFC_STAMP_SRC_EN
    r[37:35] = 3'(RouterId);
`endif
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkm(input string tag, input msg_t obs, input msg_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit ov, irdy;
    x_out_fire = 0; x_in_fire = 0; x_req0 = 0; x_req1 = 0; x_resp0 = 0; x_resp1 = 0;
    if (!m_init) return;
    chk1("d0_req_rdy", d0_req_rdy, m_iq0.size() < NumMsgs);
    chk1("d1_req_rdy", d1_req_rdy, m_iq1.size() < NumMsgs);
    ov = m_epoch ? (m_iq1.size() != 0) : (m_iq0.size() != 0);
    chk1("net_out_val", net_out_val, ov);
    chk1("net_out_sd", net_out_sd, m_epoch);
    if (ov) chkm("net_out_msg", net_out_msg, m_epoch ? m_iq1[0] : m_iq0[0]);
    irdy = net_in_sd ? (m_eq1.size() < NumMsgs) : (m_eq0.size() < NumMsgs);
    chk1("net_in_rdy", net_in_rdy, irdy);
    chk1("d0_resp_val", d0_resp_val, m_eq0.size() != 0);
    chk1("d1_resp_val", d1_resp_val, m_eq1.size() != 0);
    if (m_eq0.size() != 0) chkm("d0_resp_msg", d0_resp_msg, m_eq0[0]);
    if (m_eq1.size() != 0) chkm("d1_resp_msg", d1_resp_msg, m_eq1[0]);
    x_out_fire = ov && net_out_rdy;
    x_in_fire  = net_in_val && irdy;
    x_req0     = d0_req_val && (m_iq0.size() < NumMsgs);
    x_req1     = d1_req_val && (m_iq1.size() < NumMsgs);
    x_resp0    = d0_resp_rdy && (m_eq0.size() != 0);
    x_resp1    = d1_resp_rdy && (m_eq1.size() != 0);
  endtask

  task automatic model_update();
    acc0 = 0; acc1 = 0; acc_in = 0;
    if (!reset) begin
      m_iq0.delete(); m_iq1.delete(); m_eq0.delete(); m_eq1.delete();
      m_epoch = 0; m_slot = 0; m_init = 1;
      return;
    end
    if (!m_init) return;
    if (x_out_fire) begin
      if (m_epoch) void'(m_iq1.pop_front());
      else void'(m_iq0.pop_front());
    end
    if (x_resp0) void'(m_eq0.pop_front());
    if (x_resp1) void'(m_eq1.pop_front());
    if (x_req0) begin m_iq0.push_back(exp_inj(d0_req_msg)); acc0 = 1; end
    if (x_req1) begin m_iq1.push_back(exp_inj(d1_req_msg)); acc1 = 1; end
    if (x_in_fire) begin
      if (net_in_sd) m_eq1.push_back(net_in_msg);
      else m_eq0.push_back(net_in_msg);
      acc_in = 1;
    end
    if (m_slot == int'(EpochCycles) - 1) begin
      m_slot = 0;
      m_epoch = ~m_epoch;
    end else begin
      m_slot++;
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising
  // edge, then retire accepted requests and give the next ejected word a new payload.
  task automatic cyc();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    if (acc0) d0_req_val = 1'b0;
    if (acc1) d1_req_val = 1'b0;
    if (acc_in) net_in_msg = net_in_msg + 41'd1;
  endtask

  task automatic send0(input msg_t m);
    d0_req_val = 1'b1;
    d0_req_msg = m;
  endtask

  task automatic send1(input msg_t m);
    d1_req_val = 1'b1;
    d1_req_msg = m;
  endtask

  initial begin
    // Reset for two cycles, release on an edge so t=0 is an epoch-0 cycle.
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    net_out_rdy = 1'b1; d0_resp_rdy = 1'b1; d1_resp_rdy = 1'b1;
    cyc();                                     // t=0

    // Single message per domain at t=1: d0 out at t=2, d1 out at t=3.
    send0(mk(3'd2, 3'd0, 3'd1, 32'h0000_00a1));
    send1(mk(3'd3, 3'd0, 3'd2, 32'h0000_00b1));
    repeat (4) cyc();

    // Fill iq0 while the router stalls; a third d0 request must wait.
    net_out_rdy = 1'b0;
    send0(mk(3'd1, 3'd6, 3'd0, 32'h0000_0a02)); cyc();
    send0(mk(3'd1, 3'd0, 3'd3, 32'h0000_0a03)); cyc();
    send0(mk(3'd4, 3'd2, 3'd4, 32'h0000_0a04));
    repeat (2) cyc();
    // Router ready only in epoch 1: d1 keeps injecting, iq0 stays full.
    for (int i = 0; i < 8; i++) begin
      net_out_rdy = m_epoch;
      if (!d1_req_val) send1(mk(3'd5, 3'(i), 3'd1, 32'h0000_0b10 + 32'(i)));
      cyc();
    end
    net_out_rdy = 1'b1;
    d1_req_val = 1'b0;
    repeat (6) cyc();

    // Ejection: d1 consumer stalled, three sd=1 words -> third is refused;
    // sd=0 traffic still flows to d0.
    d1_resp_rdy = 1'b0; d0_resp_rdy = 1'b1;
    net_in_val = 1'b1; net_in_sd = 1'b1;
    net_in_msg = mk(3'd0, 3'd1, 3'd0, 32'h0000_e100);
    repeat (3) cyc();
    net_in_sd = 1'b0;
    net_in_msg = mk(3'd0, 3'd2, 3'd0, 32'h0000_e000);
    repeat (2) cyc();
    net_in_val = 1'b0;
    cyc();
    d1_resp_rdy = 1'b1;
    repeat (3) cyc();

    // Simultaneous injection, ejection and consumption in every cycle.
    net_in_val = 1'b1;
    for (int i = 0; i < 6; i++) begin
      net_in_sd = i[0];
      if (!d0_req_val) send0(mk(3'd6, 3'd7, 3'(i), 32'h0000_c000 + 32'(i)));
      if (!d1_req_val) send1(mk(3'd7, 3'd1, 3'(i), 32'h0000_d000 + 32'(i)));
      cyc();
    end
    net_in_val = 1'b0; d0_req_val = 1'b0; d1_req_val = 1'b0;
    repeat (4) cyc();

    // Load two messages in every queue, then reset mid-operation.
    net_out_rdy = 1'b0; d0_resp_rdy = 1'b0; d1_resp_rdy = 1'b0;
    net_in_val = 1'b1; net_in_sd = 1'b0;
    net_in_msg = mk(3'd2, 3'd3, 3'd1, 32'h0000_f000);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        send0(mk(3'd2, 3'd2, 3'd2, 32'h0000_f100 + 32'(i)));
        send1(mk(3'd3, 3'd3, 3'd3, 32'h0000_f200 + 32'(i)));
      end
      net_in_sd = (i >= 2);
      cyc();
    end
    net_in_val = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    net_out_rdy = 1'b1; d0_resp_rdy = 1'b1; d1_resp_rdy = 1'b1;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
